// File: rtl/zbkb_arb.sv
// zbkb_arb: two-port valid/ready arbiter and sequencer for the shared,
// purely combinational ZBKB bit-manipulation unit. One operation is in
// flight at a time: IDLE (accept) -> EXEC (unit evaluates registered
// operands) -> RESP (result held until the owning requester takes it).
//
// Configuration macro: ZBKB_ARB_RR_EN
//   defined   - round-robin between the two requesters using LastGrant
//   undefined - fixed priority, requester 0 always wins; no LastGrant flop
module zbkb_arb #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        Flush,
  input  logic [1:0]                  ReqValid,
  output logic [1:0]                  ReqReady,
  input  logic [1:0][WIDTH-1:0]       ReqA,
  input  logic [1:0][WIDTH/2-1:0]     ReqB,
  input  logic [1:0][2:0]             ReqFunct3,
  input  logic [1:0][2:0]             ReqSelect,
  output logic [WIDTH-1:0]            UA,
  output logic [WIDTH/2-1:0]          UB,
  output logic [2:0]                  UFunct3,
  output logic [2:0]                  USelect,
  input  logic [WIDTH-1:0]            UResult,
  output logic [1:0]                  RspValid,
  input  logic [1:0]                  RspReady,
  output logic [WIDTH-1:0]            RspResult
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic [WIDTH-1:0]     ua_q, ua_d;
  logic [WIDTH/2-1:0]   ub_q, ub_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [2:0]           select_q, select_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic [1:0]           grant;
  logic                 accept;
  logic                 acc_idx;

`ifdef ZBKB_ARB_RR_EN
  logic                 last_grant_q, last_grant_d;

  // Round-robin grant: on contention the requester that did not win last time goes.
  always_comb begin
    grant = 2'b00;
    case (ReqValid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`else
  // Fixed-priority grant: requester 0 wins whenever it is valid.
  always_comb begin
    grant = 2'b00;
    if (ReqValid[0]) begin
      grant = 2'b01;
    end else if (ReqValid[1]) begin
      grant = 2'b10;
    end
  end
`endif

  // Acceptance is purely a function of state, Flush and ReqValid; reset masks it
  // so no requester sees a handshake while resetn is low.
  assign ReqReady = (resetn && (state_q == IDLE) && !Flush) ? grant : 2'b00;
  assign accept   = |ReqReady;
  assign acc_idx  = ReqReady[1];

  // Next-state and register-load decode; Flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ua_d     = ua_q;
    ub_d     = ub_q;
    funct3_d = funct3_q;
    select_d = select_q;
    result_d = result_q;
`ifdef ZBKB_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EXEC;
          owner_d  = acc_idx;
          ua_d     = ReqA[acc_idx];
          ub_d     = ReqB[acc_idx];
          funct3_d = ReqFunct3[acc_idx];
          select_d = ReqSelect[acc_idx];
`ifdef ZBKB_ARB_RR_EN
          last_grant_d = acc_idx;
`endif
        end
      end
      EXEC: begin
        // The unit is combinational on the registered operands, so its
        // output is valid one cycle after the operands were loaded.
        state_d  = RESP;
        result_d = UResult;
      end
      RESP: begin
        // Only the owner's ready completes the response.
        if (RspReady[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (Flush) begin
      state_d = IDLE;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef ZBKB_ARB_RR_EN
  // Last winner; resets to requester 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Operand and result registers; Flush leaves the operands untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ua_q     <= '0;
      ub_q     <= '0;
      funct3_q <= '0;
      select_q <= '0;
      result_q <= '0;
    end else begin
      ua_q     <= ua_d;
      ub_q     <= ub_d;
      funct3_q <= funct3_d;
      select_q <= select_d;
      result_q <= result_d;
    end
  end

  assign UA        = ua_q;
  assign UB        = ub_q;
  assign UFunct3   = funct3_q;
  assign USelect   = select_q;
  assign RspResult = result_q;
  assign RspValid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_zbkb_arb.sv
module tb_zbkb_arb;
  localparam int WIDTH = 32;

  logic                    clk;
  logic                    resetn;
  logic                    Flush;
  logic [1:0]              ReqValid;
  logic [1:0]              ReqReady;
  logic [1:0][WIDTH-1:0]   ReqA;
  logic [1:0][WIDTH/2-1:0] ReqB;
  logic [1:0][2:0]         ReqFunct3;
  logic [1:0][2:0]         ReqSelect;
  logic [WIDTH-1:0]        UA;
  logic [WIDTH/2-1:0]      UB;
  logic [2:0]              UFunct3;
  logic [2:0]              USelect;
  logic [WIDTH-1:0]        UResult;
  logic [1:0]              RspValid;
  logic [1:0]              RspReady;
  logic [WIDTH-1:0]        RspResult;

  int errors = 0;
  int checks = 0;

  zbkb_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn), .Flush(Flush),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA(ReqA), .ReqB(ReqB), .ReqFunct3(ReqFunct3), .ReqSelect(ReqSelect),
    .UA(UA), .UB(UB), .UFunct3(UFunct3), .USelect(USelect),
    .UResult(UResult),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the ZBKB unit: brev8 (bit reverse within each byte) for select 000.
  function automatic logic [31:0] brev8(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = x[8*b+7-i];
    return r;
  endfunction

  assign UResult = (USelect == 3'b000) ? brev8(UA) : ~UA;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w;
    logic [1:0]  exp_gnt;
    // Reset
    resetn = 1'b0; Flush = 1'b0; ReqValid = 2'b01; RspReady = 2'b00;
    ReqA = '0; ReqB = '0; ReqFunct3 = '0; ReqSelect = '0;
    @(negedge clk);
    chk("rst_reqready", ReqReady, 2'b00);
    chk("rst_rspvalid", RspValid, 2'b00);
    chk("rst_rspresult", RspResult, 0);
    chk("rst_ua", UA, 0);
    chk("rst_ub", UB, 0);
    chk("rst_f3_sel", {UFunct3, USelect}, 0);
    next_cycle();
    resetn = 1'b1; ReqValid = 2'b00;

    // Contention, both valid continuously, RspReady=11
    ReqA[0] = 32'h0000_0001; ReqA[1] = 32'h0000_0080;
    for (int k = 0; k < 4; k++) begin
`ifdef ZBKB_ARB_RR_EN
      w = k[0];
`else
      w = 1'b0;
`endif
      exp_gnt = w ? 2'b10 : 2'b01;
      next_cycle();
      ReqValid = 2'b11; RspReady = 2'b11;
      @(negedge clk);
      chk("cont_grant", ReqReady, exp_gnt);
      next_cycle();
      @(negedge clk);
      chk("cont_exec_ua", UA, w ? 32'h0000_0080 : 32'h0000_0001);
      chk("cont_exec_rdy", ReqReady, 2'b00);
      next_cycle();
      @(negedge clk);
      chk("cont_rspvalid", RspValid, exp_gnt);
      chk("cont_rspresult", RspResult, w ? 32'h0000_0001 : 32'h0000_0080);
    end

    // Single op, requester 0
    next_cycle();
    ReqValid = 2'b01; RspReady = 2'b00;
    ReqA[0] = 32'h0102_0304; ReqB[0] = 16'h1234; ReqFunct3[0] = 3'b101; ReqSelect[0] = 3'b000;
    @(negedge clk);
    chk("single_ready", ReqReady, 2'b01);
    next_cycle();
    ReqValid = 2'b00;
    @(negedge clk);
    chk("single_exec_valid", RspValid, 2'b00);
    chk("single_ua", UA, 32'h0102_0304);
    chk("single_ub", UB, 16'h1234);
    chk("single_f3", UFunct3, 3'b101);
    next_cycle();
    RspReady = 2'b01;
    @(negedge clk);
    chk("single_rspvalid", RspValid, 2'b01);
    chk("single_result", RspResult, 32'h8040_C020);
    next_cycle();
    RspReady = 2'b00;
    @(negedge clk);
    chk("single_done", RspValid, 2'b00);

    // Flush in IDLE blocks acceptance
    next_cycle();
    Flush = 1'b1; ReqValid = 2'b01;
    @(negedge clk);
    chk("flush_idle_ready", ReqReady, 2'b00);
    next_cycle();
    Flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_after", ReqReady, 2'b01);
    // Flush in EXEC
    next_cycle();
    ReqValid = 2'b00; Flush = 1'b1; RspReady = 2'b01;
    @(negedge clk);
    chk("flush_exec_valid", RspValid, 2'b00);
    next_cycle();
    Flush = 1'b0; ReqValid = 2'b01;
    @(negedge clk);
    chk("flush_exec_norsp", RspValid, 2'b00);
    chk("flush_exec_idle", ReqReady, 2'b01);
    // Flush in RESP
    next_cycle();
    ReqValid = 2'b00; RspReady = 2'b00;
    next_cycle();
    Flush = 1'b1;
    @(negedge clk);
    chk("flush_resp_valid", RspValid, 2'b01);
    next_cycle();
    Flush = 1'b0; ReqValid = 2'b10;
    ReqA[1] = 32'h0000_000F; ReqB[1] = 16'h0000; ReqFunct3[1] = 3'b000; ReqSelect[1] = 3'b000;
    @(negedge clk);
    chk("flush_resp_norsp", RspValid, 2'b00);
    chk("flush_resp_idle", ReqReady, 2'b10);

    // Backpressure on requester 1 (handshake happened in the cycle above)
    next_cycle();
    ReqValid = 2'b11;
    @(negedge clk);
    chk("bp_exec_ready", ReqReady, 2'b00);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      RspReady = 2'b01;
      @(negedge clk);
      chk("bp_valid", RspValid, 2'b10);
      chk("bp_result", RspResult, 32'h0000_00F0);
      chk("bp_ready", ReqReady, 2'b00);
    end
    next_cycle();
    ReqValid = 2'b00; RspReady = 2'b10;
    @(negedge clk);
    chk("bp_take", RspValid, 2'b10);
    next_cycle();
    RspReady = 2'b00;
    @(negedge clk);
    chk("bp_done", RspValid, 2'b00);

    // Async reset mid-RESP after a requester-0 win
    next_cycle();
    ReqValid = 2'b01; ReqA[0] = 32'h0102_0304;
    @(negedge clk);
    chk("ar_accept", ReqReady, 2'b01);
    next_cycle();
    ReqValid = 2'b00;
    next_cycle();
    @(negedge clk);
    chk("ar_resp", RspValid, 2'b01);
    resetn = 1'b0;
    #1;
    chk("ar_rspvalid", RspValid, 2'b00);
    chk("ar_rspresult", RspResult, 0);
    chk("ar_ua", UA, 0);
    next_cycle();
    resetn = 1'b1; ReqValid = 2'b11;
    @(negedge clk);
    chk("ar_first_contest", ReqReady, 2'b01);
    next_cycle();
    ReqValid = 2'b00;
    @(negedge clk);
    chk("ar_exec_ua", UA, 32'h0102_0304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/zbkb_arb.md
# zbkb_arb

Sequencing controller and two-port arbiter for the shared ZBKB crypto bit-manipulation unit inside the KMU. It accepts operations from two requesters over valid/ready channels, grants the single combinational ZBKB datapath to one of them, and registers the operands into it. It then captures the unit's result and holds it on a one-hot response channel until the owning requester takes it. One operation is in flight at a time. A pipeline flush kills the in-flight operation.

## Interface
Parameters:
- WIDTH, 32, datapath width (32 or 64); matches the ZBKB unit's WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- Flush  in  1  kill in-flight operation and drop held result.
- ReqValid  in  2  per-requester request valid.
- ReqReady  out  2  per-requester request accepted this cycle.
- ReqA  in  2×WIDTH  per-requester operand A.
- ReqB  in  2×WIDTH/2  per-requester operand B.
- ReqFunct3  in  2×3  per-requester Funct3.
- ReqSelect  in  2×3  per-requester ZBKBSelect.
- UA  out  WIDTH  registered operand A to the unit.
- UB  out  WIDTH/2  registered operand B to the unit.
- UFunct3  out  3  registered Funct3 to the unit.
- USelect  out  3  registered ZBKBSelect to the unit.
- UResult  in  WIDTH  unit result (combinational from the U* operands).
- RspValid  out  2  one-hot response valid; bit = owning requester.
- RspReady  in  2  per-requester response ready.
- RspResult  out  WIDTH  held result.

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant is computed from ReqValid.
  - ReqReady[i] = IDLE & ~Flush & Grant[i].
  - On a handshake, the granted requester's operands load into UA/UB/UFunct3/USelect, Owner ← i, LastGrant ← i, and the state moves to EXEC.
  - With no valid request, the state stays in IDLE.
- EXEC: at the edge, RspResult ← UResult and the state moves to RESP.
- RESP:
  - RspValid[Owner] = 1.
  - When RspReady[Owner] is high, the state moves to IDLE.
  - RspReady of the non-owner is ignored.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid, round-robin: the requester ≠ LastGrant wins.
  - LastGrant resets to 1, so requester 0 wins the first contest.
- Flush:
  - In any state, the next state is IDLE.
  - The held result is dropped and RspValid is 0 from the next cycle.
  - Flush in IDLE blocks acceptance: ReqReady = 0 that cycle.
  - The U* registers are not cleared.
- ReqReady depends combinationally on ReqValid and Flush. It never depends on RspReady.
- Requesters hold request fields stable while ReqValid & ~ReqReady. The block does not check this.

## Timing
- Reset values:
  - ReqReady 0 during reset, then combinational.
  - RspValid 0. RspResult 0.
  - UA/UB/UFunct3/USelect 0. Owner 0. LastGrant 1.
- Latency: request handshake in cycle N gives RspValid in cycle N+2. Response handshake in cycle M allows the earliest next request handshake in cycle M+1.
- Maximum throughput: one operation per 3 cycles.
- RspResult and RspValid are stable while waiting in RESP.
- Reset asserted mid-operation: immediate return to reset values, with no response.
- Flush and a response handshake in the same cycle: the response counts as delivered and the state goes to IDLE.

## Configuration
- ZBKB_ARB_RR_EN:
  - Defined: round-robin arbitration using the LastGrant register.
  - Undefined: fixed priority, requester 0 always wins. The LastGrant register is not built.

## Test plan
- Single op, requester 0 (WIDTH=32):
  - Stimulus: ReqA0=0x01020304, Select=000, handshake cycle 0.
  - Response: RspValid=01 in cycle 2, RspResult=0x8040C020.
- Contention, RR enabled:
  - Stimulus: both valid continuously, RspReady=11.
  - Response: grants alternate 0,1,0,1. A new grant every 3 cycles.
- Contention, RR disabled:
  - Stimulus: same as the RR-enabled contention case.
  - Response: requester 0 is granted every time, and requester 1's ReqReady stays 0.
- Backpressure:
  - Stimulus: requester 1 with A=0x0000000F, Select=000, and RspReady[1]=0 for 5 cycles.
  - Response: RspValid=10 and RspResult=0x000000F0 held for the whole period. ReqReady=00 throughout.
- Flush in EXEC and in RESP:
  - Response: no response is delivered and the block is in IDLE the next cycle.
  - Flush in IDLE with ReqValid=01: ReqReady=00 that cycle.
- Async reset:
  - Stimulus: resetn low mid-RESP.
  - Response: RspValid=00 and RspResult=0 immediately. The first contest after release is won by requester 0.
